bp_perf_monitor: RTL and testbench
==================================

BP_PERF_MONITOR -- requirements
Module: bp_perf_monitor

Interface
REQ-001 Parameter CNT_W, default 16: width of every event counter.
REQ-002 Parameter NUM_TYPES, default 2: number of branch-type classes tracked; legal range 1..16.
REQ-003 Parameter TYPE_W, default 4: width of br_type and rd_sel type field; NUM_TYPES <= 2**TYPE_W.
REQ-004 clk  input  1  sole clock, rising-edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  begin a measurement run (level sampled each cycle).
REQ-007 finish  input  1  end of program; terminates the run.
REQ-008 stall  input  1  memory stall asserted this cycle.
REQ-009 flush  input  1  instruction flush (mispredict) this cycle.
REQ-010 br_valid  input  1  a branch resolved this cycle.
REQ-011 br_type  input  TYPE_W  class of the resolved branch.
REQ-012 rd_sel  input  TYPE_W+2  counter select: 0 cycles, 1 stalls, 2 flushes, 3 reserved, 4+k branch class k (per-type flush class k when macro enabled, see Configuration).
REQ-013 rd_data  output  CNT_W  registered value of the selected counter.
REQ-014 done  output  1  run complete, counters frozen.
REQ-015 running  output  1  state is RUN.
REQ-016 sat  output  1  sticky: some counter saturated this run.

Function
REQ-017 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-018 IDLE: all counters zero; start=1 -> RUN next cycle with all counters cleared.
REQ-019 RUN: cycle counter increments every cycle, including the cycle finish is sampled.
REQ-020 RUN: stall=1 increments stall counter; flush=1 increments flush counter; both in the same cycle increment both.
REQ-021 RUN: br_valid=1 with br_type < NUM_TYPES increments branch counter br_type; br_type >= NUM_TYPES is dropped silently.
REQ-022 RUN: finish=1 -> DONE next cycle; that cycle's events are counted; finish has priority over start.
REQ-023 DONE: counters hold, done=1; start=1 clears all counters and sat and enters RUN next cycle.
REQ-024 Events outside RUN are never counted.
REQ-025 Counters saturate at 2**CNT_W-1 (no wrap); any saturating increment sets sat.
REQ-026 rd_data updates one cycle after rd_sel is sampled; rd_sel value 3 or beyond implemented counters returns 0.
REQ-027 running and done are registered outputs decoded from state, never both 1.

Reset
REQ-028 rst_n low asynchronously forces IDLE, all counters 0, rd_data 0, done 0, running 0, sat 0, including mid-run.
REQ-029 First state change after rst_n rises occurs on the first rising clk edge with start=1.

Configuration
REQ-030 Macro BP_PERF_TYPE_FLUSH_EN: when defined, a second counter bank counts cycles with flush=1 and br_valid=1 per br_type, read at rd_sel 4+NUM_TYPES+k; when undefined, that bank is absent and those selects return 0.

Structure
REQ-031 Shared package bp_perf_pkg holds the FSM state enum, rd_sel base constants (SEL_CYCLE, SEL_STALL, SEL_FLUSH, SEL_TYPE_BASE) and the counter-width default.
REQ-032 One sub-module sat_counter (parametrised CNT_W; clear, inc, value, sat_hit) is instantiated for every counter.

Verification
REQ-033 Reset release, start=1 for 1 cycle, 10 cycles RUN with stall on cycles 2-4, finish on cycle 10 -> cycles=10, stalls=3, done=1 next cycle.
REQ-034 Flush and stall together for 5 cycles in RUN -> stall counter 5, flush counter 5.
REQ-035 NUM_TYPES=2, br_valid with types 0,1,1,3 -> class0=1, class1=2, type 3 dropped, rd_sel 6 reads 0.
REQ-036 CNT_W=4, 20 RUN cycles -> cycle counter holds 15, sat=1; start in DONE clears to 0 and sat=0.
REQ-037 rst_n low for 1 ns mid-run at cycles=7 -> all outputs 0 immediately, state IDLE, events ignored until start.
REQ-038 With BP_PERF_TYPE_FLUSH_EN, 3 flush+br_valid type 1 cycles -> rd_sel 4+NUM_TYPES+1 reads 3; without macro reads 0.

Source files
------------

// File: rtl/bp_perf_pkg.sv
// Shared definitions for the branch-predictor performance monitor:
// FSM state encoding, read-select map and default counter width.
package bp_perf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int CNT_W_DEFAULT = 16;

    localparam int SEL_CYCLE     = 0;
    localparam int SEL_STALL     = 1;
    localparam int SEL_FLUSH     = 2;
    localparam int SEL_TYPE_BASE = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sat_hit flags an increment
// that was swallowed because the counter already sits at its maximum.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] value,
    output logic             sat_hit
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    assign sat_hit = inc && !clear && (value == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc && (value != CNT_MAX)) begin
            value <= value + CNT_W'(1);
        end
    end

endmodule

// File: rtl/bp_perf_monitor.sv
// Run-based event counters (cycles, stalls, flushes, per-class branches) with a
// registered read port. Optional per-class flush bank: BP_PERF_TYPE_FLUSH_EN.
//   state   | meaning
//   ST_IDLE | after reset, counters zero, waiting for start
//   ST_RUN  | counting events until finish
//   ST_DONE | counters frozen for readout, start begins a new run
module bp_perf_monitor
    import bp_perf_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEFAULT,
    parameter int NUM_TYPES = 2,
    parameter int TYPE_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              stall,
    input  logic              flush,
    input  logic              br_valid,
    input  logic [TYPE_W-1:0] br_type,
    input  logic [TYPE_W+1:0] rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic              done,
    output logic              running,
    output logic              sat
);

    localparam int SEL_W = TYPE_W + 2;

    state_t state, state_nxt;
    logic   clr_all, cnt_en, running_nxt, done_nxt, any_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)  state_nxt = ST_RUN;
            ST_RUN:  if (finish) state_nxt = ST_DONE;
            ST_DONE: if (start)  state_nxt = ST_RUN;
            default:             state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_en      = (state == ST_RUN);
        clr_all     = (state != ST_RUN) && start;
        running_nxt = (state_nxt == ST_RUN);
        done_nxt    = (state_nxt == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            running <= running_nxt;
            done    <= done_nxt;
        end
    end

    logic [CNT_W-1:0] cyc_val, stall_val, flush_val;
    logic             cyc_hit, stall_hit, flush_hit;

    sat_counter #(.CNT_W(CNT_W)) u_cyc (
        .clk(clk), .rst_n(rst_n), .clear(clr_all), .inc(cnt_en),
        .value(cyc_val), .sat_hit(cyc_hit)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall (
        .clk(clk), .rst_n(rst_n), .clear(clr_all), .inc(cnt_en && stall),
        .value(stall_val), .sat_hit(stall_hit)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush (
        .clk(clk), .rst_n(rst_n), .clear(clr_all), .inc(cnt_en && flush),
        .value(flush_val), .sat_hit(flush_hit)
    );

    // Types at or above NUM_TYPES match no bank entry and are dropped.
    logic [CNT_W-1:0]     br_val [NUM_TYPES];
    logic [NUM_TYPES-1:0] br_inc, br_hit;

    for (genvar k = 0; k < NUM_TYPES; k++) begin : g_br
        assign br_inc[k] = cnt_en && br_valid && (br_type == TYPE_W'(k));

        sat_counter #(.CNT_W(CNT_W)) u_br (
            .clk(clk), .rst_n(rst_n), .clear(clr_all), .inc(br_inc[k]),
            .value(br_val[k]), .sat_hit(br_hit[k])
        );
    end

`ifdef BP_PERF_TYPE_FLUSH_EN
    logic [CNT_W-1:0]     tf_val [NUM_TYPES];
    logic [NUM_TYPES-1:0] tf_hit;

    for (genvar k = 0; k < NUM_TYPES; k++) begin : g_tf
        sat_counter #(.CNT_W(CNT_W)) u_tf (
            .clk(clk), .rst_n(rst_n), .clear(clr_all), .inc(br_inc[k] && flush),
            .value(tf_val[k]), .sat_hit(tf_hit[k])
        );
    end
`endif

    always_comb begin
        any_hit = cyc_hit | stall_hit | flush_hit | (|br_hit);
`ifdef BP_PERF_TYPE_FLUSH_EN
        any_hit = any_hit | (|tf_hit);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat <= 1'b0;
        end else if (clr_all) begin
            sat <= 1'b0;
        end else if (any_hit) begin
            sat <= 1'b1;
        end
    end

    // Unmapped selects (reserved slot, absent bank, out of range) read zero.
    logic [CNT_W-1:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (rd_sel)
            SEL_W'(SEL_CYCLE): rd_mux = cyc_val;
            SEL_W'(SEL_STALL): rd_mux = stall_val;
            SEL_W'(SEL_FLUSH): rd_mux = flush_val;
            default:           rd_mux = '0;
        endcase
        for (int k = 0; k < NUM_TYPES; k++) begin
            if (rd_sel == SEL_W'(SEL_TYPE_BASE + k)) rd_mux = br_val[k];
`ifdef BP_PERF_TYPE_FLUSH_EN
            if (rd_sel == SEL_W'(SEL_TYPE_BASE + NUM_TYPES + k)) rd_mux = tf_val[k];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_mux;
        end
    end

endmodule

// File: tb/tb_bp_perf_monitor.sv
// Self-checking bench for bp_perf_monitor: a 16-bit instance and a 4-bit
// instance share stimulus and are compared against a count-based model.
module tb_bp_perf_monitor;
    import bp_perf_pkg::*;

    localparam int NT    = 2;
    localparam int MAX16 = 65535;
    localparam int MAX4  = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0, finish = 1'b0, stall = 1'b0, flush = 1'b0, br_valid = 1'b0;
    logic [3:0]  br_type = '0;
    logic [5:0]  rd_sel = '0;
    logic [15:0] rd_data;
    logic [3:0]  rd_data_s;
    logic        done, running, sat, done_s, running_s, sat_s;

    int vectors = 0;
    int miscompares = 0;

    bp_perf_monitor #(.CNT_W(16), .NUM_TYPES(NT), .TYPE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish), .stall(stall),
        .flush(flush), .br_valid(br_valid), .br_type(br_type), .rd_sel(rd_sel),
        .rd_data(rd_data), .done(done), .running(running), .sat(sat)
    );

    bp_perf_monitor #(.CNT_W(4), .NUM_TYPES(NT), .TYPE_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish), .stall(stall),
        .flush(flush), .br_valid(br_valid), .br_type(br_type), .rd_sel(rd_sel),
        .rd_data(rd_data_s), .done(done_s), .running(running_s), .sat(sat_s)
    );

    always #5 clk = ~clk;

    // Model keeps exact (unbounded) event counts; saturation is derived on read.
    int t_cyc, t_stall, t_flush;
    int t_br [NT];
    int t_tf [NT];
    bit m_run, m_done;
    int exp_rd16, exp_rd4;

    function automatic int clip(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic int model_read(input int sel, input int mx);
        if (sel == 0) return clip(t_cyc, mx);
        if (sel == 1) return clip(t_stall, mx);
        if (sel == 2) return clip(t_flush, mx);
        if (sel >= 4 && sel < 4 + NT) return clip(t_br[sel-4], mx);
`ifdef BP_PERF_TYPE_FLUSH_EN
        if (sel >= 4 + NT && sel < 4 + 2*NT) return clip(t_tf[sel-4-NT], mx);
`endif
        return 0;
    endfunction

    function automatic bit model_sat(input int mx);
        bit s;
        s = (t_cyc > mx) || (t_stall > mx) || (t_flush > mx);
        for (int k = 0; k < NT; k++) begin
            if (t_br[k] > mx) s = 1'b1;
`ifdef BP_PERF_TYPE_FLUSH_EN
            if (t_tf[k] > mx) s = 1'b1;
`endif
        end
        return s;
    endfunction

    task automatic model_clear();
        t_cyc = 0; t_stall = 0; t_flush = 0;
        for (int k = 0; k < NT; k++) begin
            t_br[k] = 0;
            t_tf[k] = 0;
        end
    endtask

    task automatic model_reset();
        model_clear();
        m_run = 1'b0; m_done = 1'b0;
        exp_rd16 = 0; exp_rd4 = 0;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, return at the negedge.
    task automatic drive(input bit st, input bit fi, input bit sl, input bit fl,
                         input bit bv, input int bt, input int rs);
        start = st; finish = fi; stall = sl; flush = fl; br_valid = bv;
        br_type = 4'(bt); rd_sel = 6'(rs);
        @(posedge clk);
        exp_rd16 = model_read(rs, MAX16);
        exp_rd4  = model_read(rs, MAX4);
        if (m_run) begin
            t_cyc++;
            if (sl) t_stall++;
            if (fl) t_flush++;
            if (bv && bt < NT) begin
                t_br[bt]++;
                if (fl) t_tf[bt]++;
            end
            if (fi) begin
                m_run = 1'b0; m_done = 1'b1;
            end
        end else if (st) begin
            model_clear();
            m_run = 1'b1; m_done = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        vectors++;
        if ({running, done, sat, running_s, done_s, sat_s} !== 6'b0 || rd_data !== 16'd0 || rd_data_s !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: run=%0b done=%0b sat=%0b rd=%0d (small rd=%0d) expected all zero",
                     running, done, sat, rd_data, rd_data_s);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 1, 1, 0, SEL_CYCLE);
            vectors++;
            if (running !== 1'b0 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_hold: run=%0b done=%0b expected 0 0", running, done);
            end
        end
        drive(0, 0, 0, 0, 0, 0, SEL_STALL);
        vectors++;
        if (rd_data !== 16'd0) begin
            miscompares++;
            $display("FAIL idle_no_count: rd=%0d expected 0", rd_data);
        end
    endtask

    task automatic test_run_basic();
        drive(1, 0, 0, 0, 0, 0, SEL_CYCLE);
        vectors++;
        if (running !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL start_to_run: run=%0b done=%0b expected 1 0", running, done);
        end
        for (int i = 1; i <= 10; i++) drive(0, i == 10, i >= 2 && i <= 4, 0, 0, 0, SEL_CYCLE);
        vectors++;
        if (done !== 1'b1 || running !== 1'b0) begin
            miscompares++;
            $display("FAIL finish_to_done: done=%0b run=%0b expected 1 0", done, running);
        end
        drive(0, 0, 0, 0, 0, 0, SEL_CYCLE);
        vectors++;
        if (rd_data !== 16'd10) begin
            miscompares++;
            $display("FAIL basic_cycles: rd=%0d expected 10", rd_data);
        end
        drive(0, 0, 0, 0, 0, 0, SEL_STALL);
        vectors++;
        if (rd_data !== 16'd3) begin
            miscompares++;
            $display("FAIL basic_stalls: rd=%0d expected 3", rd_data);
        end
    endtask

    task automatic test_stall_flush();
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, SEL_STALL);
        vectors++;
        if (rd_data !== 16'd5) begin
            miscompares++;
            $display("FAIL both_stalls: rd=%0d expected 5", rd_data);
        end
        drive(0, 0, 0, 0, 0, 0, SEL_FLUSH);
        vectors++;
        if (rd_data !== 16'd5) begin
            miscompares++;
            $display("FAIL both_flushes: rd=%0d expected 5", rd_data);
        end
    endtask

    task automatic test_branch_types();
        int types [4] = '{0, 1, 1, 3};
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, i == 3, 0, 0, 1, types[i], 0);
        drive(0, 0, 0, 0, 0, 0, SEL_TYPE_BASE);
        vectors++;
        if (rd_data !== 16'd1) begin
            miscompares++;
            $display("FAIL br_class0: rd=%0d expected 1", rd_data);
        end
        drive(0, 0, 0, 0, 0, 0, SEL_TYPE_BASE + 1);
        vectors++;
        if (rd_data !== 16'd2) begin
            miscompares++;
            $display("FAIL br_class1: rd=%0d expected 2", rd_data);
        end
        drive(0, 0, 0, 0, 0, 0, SEL_TYPE_BASE + 2);
        vectors++;
        if (rd_data !== 16'd0) begin
            miscompares++;
            $display("FAIL br_sel6_zero: rd=%0d expected 0", rd_data);
        end
        drive(0, 0, 0, 0, 0, 0, 3);
        vectors++;
        if (rd_data !== 16'd0) begin
            miscompares++;
            $display("FAIL reserved_sel: rd=%0d expected 0", rd_data);
        end
    endtask

    task automatic test_saturation();
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 20; i++) drive(0, i == 20, 0, 0, 0, 0, SEL_CYCLE);
        drive(0, 0, 0, 0, 0, 0, SEL_CYCLE);
        vectors++;
        if (rd_data_s !== 4'd15 || sat_s !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_small: rd=%0d sat=%0b expected 15 1", rd_data_s, sat_s);
        end
        vectors++;
        if (rd_data !== 16'd20 || sat !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_wide: rd=%0d sat=%0b expected 20 0", rd_data, sat);
        end
        drive(1, 0, 0, 0, 0, 0, SEL_CYCLE);
        vectors++;
        if (sat_s !== 1'b0 || running_s !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_clear: sat=%0b run=%0b expected 0 1", sat_s, running_s);
        end
        drive(0, 0, 0, 0, 0, 0, SEL_CYCLE);
        vectors++;
        if (rd_data_s !== 4'd0) begin
            miscompares++;
            $display("FAIL restart_clear: rd=%0d expected 0", rd_data_s);
        end
        drive(0, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_type_flush();
        int want;
`ifdef BP_PERF_TYPE_FLUSH_EN
        want = 3;
`else
        want = 0;
`endif
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 1, 1, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, SEL_TYPE_BASE + NT + 1);
        vectors++;
        if (rd_data !== 16'(want)) begin
            miscompares++;
            $display("FAIL type_flush: rd=%0d expected %0d", rd_data, want);
        end
    endtask

    task automatic test_async_reset();
        drive(1, 0, 0, 0, 0, 0, SEL_CYCLE);
        for (int i = 0; i < 7; i++) drive(0, 0, 1, 1, 1, 0, SEL_CYCLE);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({running, done, sat, running_s, done_s, sat_s} !== 6'b0 || rd_data !== 16'd0 || rd_data_s !== 4'd0) begin
            miscompares++;
            $display("FAIL midrun_reset: run=%0b done=%0b sat=%0b rd=%0d expected all zero",
                     running, done, sat, rd_data);
        end
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 1, 1, 1, SEL_CYCLE);
        vectors++;
        if (running !== 1'b0 || rd_data !== 16'd0) begin
            miscompares++;
            $display("FAIL post_reset_idle: run=%0b rd=%0d expected 0 0", running, rd_data);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3),
                  $urandom_range(0, 11));
            vectors++;
            if (running !== m_run || done !== m_done || running_s !== m_run || done_s !== m_done) begin
                miscompares++;
                $display("FAIL rand_state[%0d]: run=%0b done=%0b expected %0b %0b", i, running, done, m_run, m_done);
            end
            vectors++;
            if (rd_data !== 16'(exp_rd16) || rd_data_s !== 4'(exp_rd4)) begin
                miscompares++;
                $display("FAIL rand_rd[%0d]: rd=%0d small=%0d expected %0d %0d", i, rd_data, rd_data_s, exp_rd16, exp_rd4);
            end
            vectors++;
            if (sat !== model_sat(MAX16) || sat_s !== model_sat(MAX4)) begin
                miscompares++;
                $display("FAIL rand_sat[%0d]: sat=%0b small=%0b expected %0b %0b", i, sat, sat_s, model_sat(MAX16), model_sat(MAX4));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_run_basic();
        test_stall_flush();
        test_branch_types();
        test_saturation();
        test_type_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
